instr_sequencer: RTL and testbench

- Main sequencing FSM for the simple processor; drives the 6-bit `state` bus consumed by the control unit, which registers one 20-bit control word per state code.
- Steps fetch1..fetch6, then decodes the instruction register opcode and walks the matching execute sequence.
- Returns to fetch1 after each instruction, or to idle on HALT or an illegal opcode.
- Supports memory wait stalls and counts retired instructions.

---
 rtl/proc_pkg.sv | 45 ++++
 rtl/opcode_decoder.sv | 26 ++
 rtl/instr_sequencer.sv | 127 ++++++++++++
 tb/tb_instr_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: state codes consumed by the control unit,
// opcode constants and the decoder result type.
package proc_pkg;

    localparam int STATE_W = 6;

    localparam logic [5:0] S_IDLE   = 6'd0;
    localparam logic [5:0] S_FETCH1 = 6'd1;
    localparam logic [5:0] S_FETCH2 = 6'd2;
    localparam logic [5:0] S_FETCH3 = 6'd3;
    localparam logic [5:0] S_FETCH4 = 6'd4;
    localparam logic [5:0] S_FETCH5 = 6'd5;
    localparam logic [5:0] S_FETCH6 = 6'd6;
    localparam logic [5:0] S_LDR11  = 6'd7;
    localparam logic [5:0] S_LDR12  = 6'd8;
    localparam logic [5:0] S_LDR13  = 6'd9;
    localparam logic [5:0] S_LDR14  = 6'd10;
    localparam logic [5:0] S_LDR21  = 6'd11;
    localparam logic [5:0] S_LDR22  = 6'd12;
    localparam logic [5:0] S_LDR23  = 6'd13;
    localparam logic [5:0] S_LDR24  = 6'd14;
    localparam logic [5:0] S_STAC1  = 6'd15;
    localparam logic [5:0] S_STAC2  = 6'd16;
    localparam logic [5:0] S_STAC3  = 6'd17;
    localparam logic [5:0] S_STAC4  = 6'd18;
    localparam logic [5:0] S_ADD    = 6'd19;
    localparam logic [5:0] S_ADD2   = 6'd20;
    localparam logic [5:0] S_MUL    = 6'd21;

    localparam logic [7:0] OPC_NOP  = 8'h00;
    localparam logic [7:0] OPC_LDR1 = 8'h01;
    localparam logic [7:0] OPC_LDR2 = 8'h02;
    localparam logic [7:0] OPC_STAC = 8'h03;
    localparam logic [7:0] OPC_ADD  = 8'h04;
    localparam logic [7:0] OPC_MUL  = 8'h05;
    localparam logic [7:0] OPC_HALT = 8'hFF;

    typedef struct packed {
        logic [STATE_W-1:0] first_state;
        logic               is_nop;
        logic               is_halt;
        logic               is_illegal;
    } decode_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode: first execute state plus NOP/HALT/illegal flags.
module opcode_decoder
    import proc_pkg::*;
#(
    parameter int OPC_W = 8
) (
    input  logic [OPC_W-1:0] opcode,
    output decode_t          dec
);

    always_comb begin
        dec             = '0;
        dec.first_state = S_IDLE;
        case (opcode)
            OPC_W'(OPC_NOP):  dec.is_nop = 1'b1;
            OPC_W'(OPC_LDR1): dec.first_state = S_LDR11;
            OPC_W'(OPC_LDR2): dec.first_state = S_LDR21;
            OPC_W'(OPC_STAC): dec.first_state = S_STAC1;
            OPC_W'(OPC_ADD):  dec.first_state = S_ADD;
            OPC_W'(OPC_MUL):  dec.first_state = S_MUL;
            OPC_W'(OPC_HALT): dec.is_halt = 1'b1;
            default:          dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Main instruction sequencing FSM: fetch, decode, execute, retire counting.
// Optional single-step mode is enabled by defining INSTR_SEQUENCER_STEP_EN.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int OPC_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             hold,
`ifdef INSTR_SEQUENCER_STEP_EN
    input  logic             step,
`endif
    input  logic [OPC_W-1:0] opcode,
    output logic [5:0]       state,
    output logic             busy,
    output logic             halted,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    logic [5:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    logic             resume;
    logic [5:0]       retire_target;
    decode_t          dec;

    opcode_decoder #(.OPC_W(OPC_W)) u_decoder (
        .opcode (opcode),
        .dec    (dec)
    );

`ifdef INSTR_SEQUENCER_STEP_EN
    assign resume        = start | step;
    assign retire_target = S_IDLE;
`else
    assign resume        = start;
    assign retire_target = S_FETCH1;
`endif

    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        done_d    = 1'b0;
        retire    = 1'b0;

        if (state_q == S_IDLE) begin
            if (resume) begin
                state_d   = S_FETCH1;
                halted_d  = 1'b0;
                illegal_d = 1'b0;
            end
        end else if (!hold) begin
            case (state_q)
                // Codes inside each linear sequence are contiguous.
                S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_FETCH5,
                S_LDR11, S_LDR12, S_LDR13,
                S_LDR21, S_LDR22, S_LDR23,
                S_STAC1, S_STAC2, S_STAC3,
                S_ADD: state_d = state_q + 6'd1;
                S_FETCH6: begin
                    if (dec.is_nop) begin
                        retire = 1'b1;
                    end else if (dec.is_halt) begin
                        state_d  = S_IDLE;
                        halted_d = 1'b1;
                    end else if (dec.is_illegal) begin
                        state_d   = S_IDLE;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = dec.first_state;
                    end
                end
                S_LDR14, S_LDR24, S_STAC4, S_ADD2, S_MUL: retire = 1'b1;
                default: begin
                    state_d   = S_IDLE;
                    illegal_d = 1'b1;
                end
            endcase
        end

        if (retire) begin
            state_d = retire_target;
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
        end
    end

    // busy follows the next state so it changes on the same edge as state.
    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    assign state       = state_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign illegal_op  = illegal_q;
    assign instr_done  = done_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: per-cycle expected trace checked by a monitor.
// Counter width is narrowed to 4 bits so the wrap case stays short.
module tb_instr_sequencer;

    localparam int CW = 4;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          hold;
    logic [7:0]    opcode;
    logic [5:0]    state;
    logic          busy;
    logic          halted;
    logic          illegal_op;
    logic          instr_done;
    logic [CW-1:0] instr_count;
`ifdef INSTR_SEQUENCER_STEP_EN
    logic          step;
    initial step = 1'b0;
`endif

    instr_sequencer #(.OPC_W(8), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .hold        (hold),
`ifdef INSTR_SEQUENCER_STEP_EN
        .step        (step),
`endif
        .opcode      (opcode),
        .state       (state),
        .busy        (busy),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .instr_done  (instr_done),
        .instr_count (instr_count)
    );

    typedef struct packed {
        logic [5:0]    st;
        logic          bsy;
        logic          dn;
        logic          hl;
        logic          il;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_m;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prog[0:31];
    int         pc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Opcode driver: present the next program word while in fetch6.
    always @(negedge clock) begin
        if (state == 6'd6) begin
            opcode = prog[pc];
            pc++;
        end
    end

    // Monitor: compare one expected entry per clock, just after the edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            e_m = exp_q.pop_front();
            checks++;
            if (state !== e_m.st || busy !== e_m.bsy || instr_done !== e_m.dn ||
                halted !== e_m.hl || illegal_op !== e_m.il || instr_count !== e_m.cnt) begin
                errors++;
                $display("FAIL trace t=%0t got st=%0d bsy=%0b dn=%0b hl=%0b il=%0b cnt=%0d want st=%0d bsy=%0b dn=%0b hl=%0b il=%0b cnt=%0d",
                         $time, state, busy, instr_done, halted, illegal_op, instr_count,
                         e_m.st, e_m.bsy, e_m.dn, e_m.hl, e_m.il, e_m.cnt);
            end else if (e_m.dn) begin
                $display("retire t=%0t count=%0d", $time, instr_count);
            end
        end
    end

    task automatic push(input logic [5:0] st, input logic dn, input logic hl,
                        input logic il, input logic [CW-1:0] cnt);
        exp_t e;
        e.st  = st;
        e.bsy = (st != 6'd0);
        e.dn  = dn;
        e.hl  = hl;
        e.il  = il;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic push_range(input int lo, input int hi, input logic [CW-1:0] cnt);
        for (int s = lo; s <= hi; s++) push(6'(s), 1'b0, 1'b0, 1'b0, cnt);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_start(input int cycles);
        start = 1'b1;
        repeat (cycles) @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        hold    = 1'b0;
        opcode  = 8'h00;
        pc      = 0;
        for (int i = 0; i < 32; i++) prog[i] = 8'hFF;

        // Reset state
        repeat (2) @(negedge clock);
        checks++;
        if (state !== 6'd0 || busy !== 1'b0 || halted !== 1'b0 || illegal_op !== 1'b0 ||
            instr_done !== 1'b0 || instr_count !== '0) begin
            errors++;
            $display("FAIL reset_state got st=%0d bsy=%0b hl=%0b il=%0b dn=%0b cnt=%0d want all 0",
                     state, busy, halted, illegal_op, instr_done, instr_count);
        end
        reset_n = 1'b1;
        push(0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0);
        drain();

        // MUL then HALT
        prog[0] = 8'h05; prog[1] = 8'hFF; pc = 0;
        push_range(1, 6, 0); push_range(21, 21, 0);
        push(1, 1, 0, 0, 1);
        push_range(2, 6, 1);
        push(0, 0, 1, 0, 1);
        pulse_start(1);
        drain();

        // LDR1, STAC back-to-back; start held while busy is ignored
        prog[0] = 8'h01; prog[1] = 8'h03; prog[2] = 8'hFF; pc = 0;
        push_range(1, 6, 1); push_range(7, 10, 1);
        push(1, 1, 0, 0, 2);
        push_range(2, 6, 2); push_range(15, 18, 2);
        push(1, 1, 0, 0, 3);
        push_range(2, 6, 3);
        push(0, 0, 1, 0, 3);
        pulse_start(3);
        drain();

        // LDR2 with a 3-cycle hold while in ldr22
        prog[0] = 8'h02; prog[1] = 8'hFF; pc = 0;
        push_range(1, 6, 3); push_range(11, 12, 3);
        push_range(12, 12, 3); push_range(12, 12, 3); push_range(12, 12, 3);
        push_range(13, 14, 3);
        push(1, 1, 0, 0, 4);
        push_range(2, 6, 4);
        push(0, 0, 1, 0, 4);
        pulse_start(1);
        repeat (7) @(negedge clock);
        hold = 1'b1;
        repeat (3) @(negedge clock);
        hold = 1'b0;
        drain();

        // Illegal opcode; start together with hold in idle starts normally
        prog[0] = 8'h7A; pc = 0;
        push_range(1, 6, 4);
        push(0, 0, 0, 1, 4);
        hold = 1'b1;
        start = 1'b1;
        @(negedge clock);
        hold = 1'b0;
        start = 1'b0;
        drain();

        // STAC aborted by asynchronous reset while in stac3
        prog[0] = 8'h03; pc = 0;
        push_range(1, 6, 4); push_range(15, 17, 4);
        pulse_start(1);
        repeat (8) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (state !== 6'd0 || busy !== 1'b0 || instr_count !== '0 || instr_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got st=%0d bsy=%0b cnt=%0d dn=%0b want st=0 bsy=0 cnt=0 dn=0",
                     state, busy, instr_count, instr_done);
        end
        push(0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        drain();

        // 16 NOPs: counter wraps to 0 on the 16th retire
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[16] = 8'hFF; pc = 0;
        push(1, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            push_range(2, 6, CW'(i - 1));
            push(1, 1, 0, 0, CW'(i));
        end
        push_range(2, 6, 0);
        push(0, 0, 1, 0, 0);
        pulse_start(1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
